// File: rtl/jtopl_timer_ctrl_pkg.sv
// Shared constants for the OPL timer control block: register map,
// control-byte fields and status-byte layout.
package jtopl_timer_ctrl_pkg;

  // Host port select (addr input)
  localparam logic PORT_ADDR = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  // Register map
  localparam logic [7:0] REG_VALUE_A = 8'h02;
  localparam logic [7:0] REG_VALUE_B = 8'h03;
  localparam logic [7:0] REG_CTRL    = 8'h04;

  // Control register fields (REG_CTRL)
  localparam int CTRL_CLR_BIT       = 7; // 1: clear both flags, rest ignored
  localparam int CTRL_MASK_A_BIT    = 6; // 1: flag A disabled
  localparam int CTRL_MASK_B_BIT    = 5; // 1: flag B disabled
  localparam int CTRL_LOAD_B_BIT    = 1;
  localparam int CTRL_LOAD_A_BIT    = 0;

  // Status byte layout
  localparam int STAT_IRQ_BIT    = 7;
  localparam int STAT_FLAG_A_BIT = 6;
  localparam int STAT_FLAG_B_BIT = 5;

  // Snapshot of the register-side outputs
  typedef struct packed {
    logic [7:0] value_a;
    logic [7:0] value_b;
    logic       load_a;
    logic       load_b;
    logic       flagen_a;
    logic       flagen_b;
  } timer_regs_t;

  function automatic logic [7:0] status_byte(input logic fa, input logic fb);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_IRQ_BIT]    = fa | fb;
    s[STAT_FLAG_A_BIT] = fa;
    s[STAT_FLAG_B_BIT] = fb;
    return s;
  endfunction

endpackage

// File: rtl/jtopl_timer_ctrl_if.sv
// Host bus of the timer control block: chip select, write strobe,
// port select, write data, status read-back and busy.
interface jtopl_timer_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic       addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;

  modport master (
    output cs_n, wr_n, addr, din,
    input  dout, busy
  );

  modport slave (
    input  cs_n, wr_n, addr, din,
    output dout, busy
  );
endinterface

// File: rtl/jtopl_timer_ctrl.sv
// OPL timer control: decodes host writes into timer start values,
// run levels, flag enables and flag-clear pulses, and models the
// chip's write-absorb busy time with a cenop-paced down-counter.
module jtopl_timer_ctrl
  import jtopl_timer_ctrl_pkg::*;
#(
  parameter int ADDR_WAIT = 4,
  parameter int DATA_WAIT = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cenop,
  jtopl_timer_ctrl_if.slave    bus,
  input  logic                 flag_A,
  input  logic                 flag_B,
  output logic [7:0]           value_A,
  output logic [7:0]           value_B,
  output logic                 load_A,
  output logic                 load_B,
  output logic                 flagen_A,
  output logic                 flagen_B,
  output logic                 clr_flag_A,
  output logic                 clr_flag_B
);

  localparam logic [7:0] ADDR_LD = 8'(ADDR_WAIT);
  localparam logic [7:0] DATA_LD = 8'(DATA_WAIT);

  logic       strobe;
  logic       strobe_q;
  logic       wr_ev;
  logic [7:0] sel;
  logic [7:0] busy_cnt;

  // A held strobe is one event; history clears on reset so a strobe
  // still low at reset release is seen as a fresh write.
  assign strobe = ~bus.cs_n & ~bus.wr_n;
  assign wr_ev  = strobe & ~strobe_q;

  assign bus.busy = (busy_cnt != 8'd0);
  assign bus.dout = status_byte(flag_A, flag_B);

  // Strobe history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) strobe_q <= 1'b0;
    else     strobe_q <= strobe;
  end

  // Busy counter: a write reload takes priority over the cenop decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 8'd0;
    end else if (wr_ev) begin
      busy_cnt <= (bus.addr == PORT_ADDR) ? ADDR_LD : DATA_LD;
    end else if (cenop && busy_cnt != 8'd0) begin
      busy_cnt <= busy_cnt - 8'd1;
    end
  end

  // Register select and data decode; clear pulses last exactly one clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= 8'h00;
      value_A    <= 8'h00;
      value_B    <= 8'h00;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      flagen_A   <= 1'b1;
      flagen_B   <= 1'b1;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
    end else begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (wr_ev) begin
        if (bus.addr == PORT_ADDR) begin
          sel <= bus.din;
        end else begin
          case (sel)
            REG_VALUE_A: value_A <= bus.din;
            REG_VALUE_B: value_B <= bus.din;
            REG_CTRL: begin
              if (bus.din[CTRL_CLR_BIT]) begin
                clr_flag_A <= 1'b1;
                clr_flag_B <= 1'b1;
              end else begin
                flagen_A <= ~bus.din[CTRL_MASK_A_BIT];
                flagen_B <= ~bus.din[CTRL_MASK_B_BIT];
                load_A   <= bus.din[CTRL_LOAD_A_BIT];
                load_B   <= bus.din[CTRL_LOAD_B_BIT];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
